// File: rtl/dsp_pkg.sv
// Shared DSP slice constants: operand/field widths and the ALUMODE encodings used around the ALU.
// Also holds the round-robin index helper shared by slice-sharing schedulers.
package dsp_pkg;

    localparam int OPMODE_W  = 7;
    localparam int ALUMODE_W = 4;
    localparam int DEF_WIDTH = 48;

    typedef enum logic [ALUMODE_W-1:0] {
        ALUMODE_ADD     = 4'b0000,
        ALUMODE_SUB_ZXY = 4'b0011,
        ALUMODE_XOR     = 4'b0100,
        ALUMODE_AND     = 4'b1100
    } alumode_e;

    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/dsp_alu_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after ptr, wrapping modulo N; purely combinational.
// en gates the one-hot grant only, so gnt_idx stays usable as a mux select while the consumer is stalled.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o
);

    logic found;
    int   idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = 0;
        for (int off = 0; off < N; off++) begin
            idx = int'(ptr_i) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req_i[IW'(idx)]) begin
                found     = 1'b1;
                gnt_idx_o = IW'(idx);
            end
        end
        if (found && en_i) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/dsp_alu_scheduler.sv
// Shares one DSP ALU among NREQ requesters: round-robin issue register A, response register B, 2-cycle latency.
// Backpressure: RSP_READY low stalls B, then A; REQ_READY drops while A cannot advance, no op lost or duplicated.
module dsp_alu_scheduler
    import dsp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,

    input  logic [NREQ-1:0]           req_valid_i,
    output logic [NREQ-1:0]           req_ready_o,
    input  logic [OPMODE_W*NREQ-1:0]  req_opmode_i,
    input  logic [ALUMODE_W*NREQ-1:0] req_alumode_i,
    input  logic [WIDTH*NREQ-1:0]     req_x_i,
    input  logic [WIDTH*NREQ-1:0]     req_y_i,
    input  logic [WIDTH*NREQ-1:0]     req_z_i,
    input  logic [NREQ-1:0]           req_cin_i,

    output logic [OPMODE_W-1:0]       alu_opmode_o,
    output logic [ALUMODE_W-1:0]      alu_alumode_o,
    output logic [WIDTH-1:0]          alu_x_o,
    output logic [WIDTH-1:0]          alu_y_o,
    output logic [WIDTH-1:0]          alu_z_o,
    output logic                      alu_cin_o,
    input  logic [WIDTH-1:0]          alu_out_i,
    input  logic                      alu_cout_i,

    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [IDW-1:0]            rsp_id_o,
    output logic [WIDTH-1:0]          rsp_out_o,
    output logic                      rsp_cout_o,

    output logic                      busy_o
);

    logic                 a_v_q;
    logic [IDW-1:0]       a_id_q;
    logic [OPMODE_W-1:0]  a_opmode_q;
    logic [ALUMODE_W-1:0] a_alumode_q;
    logic [WIDTH-1:0]     a_x_q, a_y_q, a_z_q;
    logic                 a_cin_q;

    logic                 b_v_q;
    logic [IDW-1:0]       b_id_q;
    logic [WIDTH-1:0]     b_out_q;
    logic                 b_cout_q;

    logic [IDW-1:0]       ptr_q, ptr_d;

    logic                 b_load, b_drain, a_free, accept, arb_en;
    logic [IDW-1:0]       gnt_idx;

    logic [OPMODE_W-1:0]  sel_opmode;
    logic [ALUMODE_W-1:0] sel_alumode;
    logic [WIDTH-1:0]     sel_x, sel_y, sel_z;
    logic                 sel_cin;

    // Ready depends only on the pipeline valids and RSP_READY, never on ALU_OUT.
    assign b_load  = a_v_q & (~b_v_q | rsp_ready_i);
    assign b_drain = b_v_q & rsp_ready_i & ~b_load;
    assign a_free  = ~a_v_q | b_load;
    assign arb_en  = a_free & rstn_i;
    assign accept  = |req_ready_o;

    rr_arbiter #(
        .N  (NREQ),
        .IW (IDW)
    ) u_arb (
        .req_i     (req_valid_i),
        .ptr_i     (ptr_q),
        .en_i      (arb_en),
        .gnt_o     (req_ready_o),
        .gnt_idx_o (gnt_idx)
    );

    always_comb begin
        sel_opmode  = '0;
        sel_alumode = '0;
        sel_x       = '0;
        sel_y       = '0;
        sel_z       = '0;
        sel_cin     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == gnt_idx) begin
                sel_opmode  = req_opmode_i[i*OPMODE_W +: OPMODE_W];
                sel_alumode = req_alumode_i[i*ALUMODE_W +: ALUMODE_W];
                sel_x       = req_x_i[i*WIDTH +: WIDTH];
                sel_y       = req_y_i[i*WIDTH +: WIDTH];
                sel_z       = req_z_i[i*WIDTH +: WIDTH];
                sel_cin     = req_cin_i[i];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = IDW'(next_idx(int'(gnt_idx), NREQ));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            a_v_q       <= 1'b0;
            a_id_q      <= '0;
            a_opmode_q  <= '0;
            a_alumode_q <= '0;
            a_x_q       <= '0;
            a_y_q       <= '0;
            a_z_q       <= '0;
            a_cin_q     <= 1'b0;
            b_v_q       <= 1'b0;
            b_id_q      <= '0;
            b_out_q     <= '0;
            b_cout_q    <= 1'b0;
            ptr_q       <= '0;
        end else begin
            ptr_q <= ptr_d;
            // ALU drive only changes on a load, so a stalled or idle A keeps the ALU inputs frozen.
            if (accept) begin
                a_v_q       <= 1'b1;
                a_id_q      <= gnt_idx;
                a_opmode_q  <= sel_opmode;
                a_alumode_q <= sel_alumode;
                a_x_q       <= sel_x;
                a_y_q       <= sel_y;
                a_z_q       <= sel_z;
                a_cin_q     <= sel_cin;
            end else if (a_free) begin
                a_v_q <= 1'b0;
            end
            if (b_load) begin
                b_v_q    <= 1'b1;
                b_id_q   <= a_id_q;
                b_out_q  <= alu_out_i;
                b_cout_q <= alu_cout_i;
            end else if (b_drain) begin
                b_v_q <= 1'b0;
            end
        end
    end

    assign alu_opmode_o  = a_opmode_q;
    assign alu_alumode_o = a_alumode_q;
    assign alu_x_o       = a_x_q;
    assign alu_y_o       = a_y_q;
    assign alu_z_o       = a_z_q;
    assign alu_cin_o     = a_cin_q;

    assign rsp_valid_o = b_v_q;
    assign rsp_id_o    = b_id_q;
    assign rsp_out_o   = b_out_q;
    assign rsp_cout_o  = b_cout_q;

    assign busy_o = a_v_q | b_v_q;

endmodule

// File: doc/dsp_alu_scheduler.md
# dsp_alu_scheduler

Shares one combinational DSP ALU slice (X/Y/Z operands, OPMODE, ALUMODE, CIN → OUT, COUT) among NREQ requesters. A round-robin arbiter selects one pending operation per cycle and registers it onto the ALU input ports. The block then captures the ALU result into a response register and returns it, tagged with the requester index, over a valid/ready handshake. It sits between the DSP slice's operand sources (accumulator loops, filter taps) and a single instance of the ALU.

## Interface
- WIDTH, 48, operand and result width; must match the attached ALU.
- NREQ, 4, number of requesters, 2..8.
- IDW, $clog2(NREQ), width of the requester tag.
- CLK  in  1  sole clock; all state updates on the rising edge.
- RSTN  in  1  reset, synchronous and active-low.
- REQ_VALID  in  NREQ  per-requester operation pending.
- REQ_READY  out  NREQ  one-hot grant: operation accepted this cycle.
- REQ_OPMODE  in  7*NREQ  packed; slice i is bits [7i+6:7i].
- REQ_ALUMODE  in  4*NREQ  packed, per requester.
- REQ_X, REQ_Y, REQ_Z  in  WIDTH*NREQ each  packed operands.
- REQ_CIN  in  NREQ  carry-in per requester.
- ALU_OPMODE / ALU_ALUMODE / ALU_X / ALU_Y / ALU_Z / ALU_CIN  out  7/4/WIDTH/WIDTH/WIDTH/1  registered drive to the ALU.
- ALU_OUT  in  WIDTH  ALU result.
- ALU_COUT  in  1  ALU carry-out.
- RSP_VALID  out  1  response holds a result.
- RSP_READY  in  1  consumer accepts the response.
- RSP_ID  out  IDW  index of the requester that issued the result.
- RSP_OUT  out  WIDTH  captured ALU_OUT.
- RSP_COUT  out  1  captured ALU_COUT.
- BUSY  out  1  issue stage or response stage occupied.

## Operation
- The block is a two-stage pipeline: issue register A (valid bit a_v, tag a_id, ALU fields) and response register B (b_v, RSP_*).
- b_load = a_v & (~b_v | RSP_READY).
- b_drain = b_v & RSP_READY & ~b_load.
- a_free = ~a_v | b_load.
- Arbitration:
  - The round-robin pointer ptr gives highest priority to ptr, then ptr+1 … wrapping modulo NREQ.
  - grant = first REQ_VALID bit at or after ptr.
  - REQ_READY = grant & {NREQ{a_free}}.
  - On an accept of index g, ptr ← (g+1) mod NREQ. Otherwise ptr holds.
- On an accept, A loads the granted requester's fields and a_v ← 1. If a_free and there are no requests, a_v ← 0.
- ALU_* outputs hold their last value while a_v = 0 and while A is stalled. They never change unless A loads.
- On b_load, B captures ALU_OUT, ALU_COUT and a_id, and b_v ← 1. On b_drain, b_v ← 0.
- The scheduler applies no OPMODE/ALUMODE checking. Fields pass through unmodified.
- REQ_VALID may deassert without a grant. Arbitration is recomputed every cycle.
- BUSY = a_v | b_v.

## Timing
- Reset (RSTN low at an edge):
  - a_v, b_v, ptr, and all ALU_* and RSP_* outputs go to 0.
  - REQ_READY = 0 during reset.
  - In-flight operations are discarded and produce no response.
- Latency:
  - Request accepted at edge k → ALU_* valid after edge k.
  - RSP_VALID high after edge k+1, provided B was free or draining.
- Throughput is one operation per cycle with RSP_READY held high.
- RSP_READY low:
  - B holds its value.
  - A holds if occupied.
  - REQ_READY falls to 0 once A is occupied.
  - No data is lost or duplicated.
- Simultaneous B drain and A→B transfer in one cycle is legal and keeps b_v = 1.
- All combinational paths (grant, REQ_READY) depend only on REQ_VALID, ptr, a_v, b_v and RSP_READY. There is no path from ALU_OUT to any ready signal.

## Structure
- Shared package dsp_pkg holds OPMODE_W=7, ALUMODE_W=4, DEF_WIDTH=48 and the ALUMODE encodings used by benches (ADD=4'b0000, SUB_ZXY=4'b0011, XOR=4'b0100, AND=4'b1100).
- Sub-module rr_arbiter (parameter N):
  - Inputs: req[N], ptr, en.
  - Outputs: one-hot gnt[N], gnt_idx.
  - It is reusable by other slice-sharing blocks.
- The top level holds the operand mux, the A/B registers and ptr.

## Test plan
- Reset: hold RSTN low for 3 cycles with all REQ_VALID high → REQ_READY=0, RSP_VALID=0 and BUSY=0 during reset. After release, the first grant goes to requester 0.
- Single op: bench ALU in "none" mode, req 1 with ALUMODE 0000, X=5, Y=3, Z=10, CIN=1 → two cycles later RSP_VALID=1, RSP_ID=1, RSP_OUT=19, RSP_COUT=0.
- Fairness: all 4 requesters held valid with RSP_READY=1 → grants 0,1,2,3,0,1 on consecutive cycles, with one response per cycle after a 2-cycle fill.
- Backpressure: hold RSP_READY=0 for 5 cycles during a stream → B holds, A holds, ALU_* are stable, and REQ_READY=0 after one accept. On release, all results arrive in order with no gaps.
- Sparse requesters: only req 2 and req 0 valid, ptr=1 → order 2,0,2,0.
- Reset mid-stream: drop RSTN with A and B full → after the reset edge RSP_VALID=0 and no stale response appears.
